speck_cipher_engine: RTL and testbench
======================================

// Module: speck_cipher_engine
// PURPOSE
//  Iterative Speck block-cipher engine; encrypts or decrypts per request (mode bit) on a shared datapath.
//  Takes a precomputed round-key vector and applies UNROLL rounds per clock.
//  Uses a valid/ready handshake on both sides. Sits between the UART command/packet layer and key storage.
// PARAMETERS
//  W       32  word width; block = 2*W. Legal values: 16, 24, 32, 48, 64.
//  ROUNDS  27  round count. Must match the Speck table for W and key size.
//  UNROLL  1   rounds per clock. Must divide ROUNDS evenly; elaboration error otherwise.
//  ALPHA   (W==16)?7:8  right-rotate amount for x.
//  BETA    (W==16)?2:3  left-rotate amount for y.
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          reset: one clock; reset is synchronous and active-low
//  in_valid   in   1          request present
//  in_ready   out  1          engine can accept (state IDLE)
//  in_mode    in   1          0 = encrypt, 1 = decrypt
//  in_x       in   W          block upper word (pt for enc, ct for dec)
//  in_y       in   W          block lower word
//  rk_flat    in   W*ROUNDS   round keys; key i at [i*W +: W]; held stable by owner while busy
//  out_valid  out  1          result present; held until accepted
//  out_ready  in   1          downstream accepts result
//  out_x      out  W          result upper word
//  out_y      out  W          result lower word
//  out_mode   out  1          mode of the result
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE, in_ready=1 on the following cycle. out_valid, out_x, out_y,
//   out_mode, round counter and x/y all 0. Reset mid-operation discards the operation; no result emitted.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&&in_ready at an edge latches x,y,mode and goes to RUN.
//         Round index: enc starts at 0; dec starts at ROUNDS-1.
//   RUN: in_ready=0. Each clock applies UNROLL chained rounds.
//         enc uses keys idx..idx+UNROLL-1 ascending; dec uses idx..idx-UNROLL+1 descending.
//         After ROUNDS/UNROLL clocks, the result is registered into out_x/out_y, out_valid=1, state goes to DONE.
//   DONE: out_valid=1 with stable data until out_valid&&out_ready at an edge; then out_valid=0 and state goes to IDLE.
//         in_ready=0 in DONE. The next request is accepted no earlier than the cycle after the handshake.
//  Latency: accept edge to out_valid high = ROUNDS/UNROLL clocks (27 for defaults).
//   Throughput is one block per ROUNDS/UNROLL+2 clocks when out_ready is tied high.
//  Enc round: x' = (ROR(x,ALPHA)+y) ^ k;  y' = ROL(y,BETA) ^ x'.
//  Dec round: y' = ROR(x^y,BETA);  x' = ROL((x^k)-y',ALPHA).
//  All arithmetic is mod 2^W: wrap-around, carry/borrow discarded.
//  in_valid while not IDLE is ignored; no request is buffered. in_x, in_y, in_mode are don't-care when in_valid=0.
//  Round index never leaves [0, ROUNDS-1]. The rk_flat slice is selected by the current index only.
// CONFIGURATION
//  SPECK_ABORT_EN defined:
//   - Adds input port `abort` (1 bit).
//   - abort=1 at an edge in RUN or DONE: state goes to IDLE, out_valid=0, x/y/out_x/out_y zeroed; no result is emitted.
//   - abort in IDLE: no effect, and any in_valid that same cycle is NOT accepted (abort has priority).
//   - If abort and out_ready arrive together in DONE, the transfer does not count as accepted.
//  SPECK_ABORT_EN undefined: no abort port; an operation always runs to completion.
// STRUCTURE
//  speck_pkg:
//   - mode constants MODE_ENC/MODE_DEC
//   - FSM state encodings
//   - alpha/beta selection function of W
//   - legal (W, ROUNDS) table constants
//  Sub-module speck_round_unit (combinational, one round with enc/dec select).
//   The engine instantiates UNROLL copies in a chain.
//   The engine owns the FSM, round counter, key slicing and output register.
// TESTING
//  1 Speck64/128 encrypt: W=32, ROUNDS=27, UNROLL=1.
//    key 1b1a1918_13121110_0b0a0908_03020100, bench expands round keys.
//    pt x=3b726574 y=7475432d -> out_x=8c6fa548 out_y=454e028b; out_valid exactly 27 clocks after accept.
//  2 Decrypt of the same ct with the same keys -> 3b726574/7475432d, out_mode=1.
//  3 UNROLL=3: vectors 1 and 2 give identical results with latency 9.
//    W=16, ROUNDS=22: Speck32/64 vector pt 6574/694c -> ct a868/42f2.
//  4 Backpressure: out_ready=0 for 50 clocks -> out_valid and data stable, in_ready=0, extra in_valid ignored.
//    Then out_ready=1 -> one handshake, in_ready=1 on the next cycle.
//  5 Reset: rst=0 at RUN round 10 -> next cycle out_valid=0, in_ready=1; no stale result appears afterwards.
//  6 SPECK_ABORT_EN: abort at RUN round 5 -> IDLE, no out_valid.
//    abort with in_valid in IDLE -> request not taken. Without the macro, the port is absent.

Source files
------------

// File: rtl/speck_pkg.sv
// speck_pkg: shared constants, FSM encoding and parameter helpers for the Speck engine
package speck_pkg;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int alpha_of(input int w);
    return w == 16 ? 7 : 8;
  endfunction
  function automatic int beta_of(input int w);
    return w == 16 ? 2 : 3;
  endfunction
  function automatic bit legal_cfg(input int w, input int r);
    return (w == 16 && r == 22) || (w == 24 && (r == 22 || r == 23)) ||
           (w == 32 && (r == 26 || r == 27)) || (w == 48 && (r == 28 || r == 29)) ||
           (w == 64 && r >= 32 && r <= 34);
  endfunction
endpackage

// File: rtl/speck_round_unit.sv
// speck_round_unit: one combinational Speck round, encrypt or decrypt selected by mode
module speck_round_unit #(
  parameter int W = 32,
  parameter int ALPHA = 8,
  parameter int BETA = 3
) (
  input  logic         mode,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] k,
  output logic [W-1:0] xo,
  output logic [W-1:0] yo
);
  logic [W-1:0] xe, ye, t, yd, u, xd;
  assign xe = ((x >> ALPHA) | (x << (W - ALPHA))) + y ^ k;
  assign ye = ((y << BETA) | (y >> (W - BETA))) ^ xe;
  assign t  = x ^ y;
  assign yd = (t >> BETA) | (t << (W - BETA));
  assign u  = (x ^ k) - yd;
  assign xd = (u << ALPHA) | (u >> (W - ALPHA));
  assign xo = mode ? xd : xe;
  assign yo = mode ? yd : ye;
endmodule

// File: rtl/speck_cipher_engine.sv
// speck_cipher_engine: iterative Speck enc/dec engine, UNROLL rounds per clock, valid/ready on both sides.
// Define SPECK_ABORT_EN to add an abort input that cancels a running or pending operation.
module speck_cipher_engine
  import speck_pkg::*;
#(
  parameter int W = 32,
  parameter int ROUNDS = 27,
  parameter int UNROLL = 1,
  parameter int ALPHA = alpha_of(W),
  parameter int BETA = beta_of(W)
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SPECK_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [W-1:0]        in_x,
  input  logic [W-1:0]        in_y,
  input  logic [W*ROUNDS-1:0] rk_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_x,
  output logic [W-1:0]        out_y,
  output logic                out_mode
);
  localparam int IW = $clog2(ROUNDS);
  if (ROUNDS % UNROLL != 0) begin : g_bad_unroll
    $error("UNROLL must divide ROUNDS");
  end
  if (!legal_cfg(W, ROUNDS)) begin : g_bad_cfg
    $error("illegal (W, ROUNDS) combination for Speck");
  end
  state_t state;
  logic [IW-1:0] idx;
  logic [W-1:0] x, y;
  logic mode, last;
  logic [W-1:0] xs [UNROLL+1];
  logic [W-1:0] ys [UNROLL+1];
  logic [W-1:0] ks [UNROLL];
  assign xs[0] = x;
  assign ys[0] = y;
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [IW:0] ki;
    assign ki = mode ? {1'b0, idx} - (IW+1)'(i) : {1'b0, idx} + (IW+1)'(i);
    assign ks[i] = ki < (IW+1)'(ROUNDS) ? rk_flat[int'(ki)*W +: W] : '0;
    speck_round_unit #(.W(W), .ALPHA(ALPHA), .BETA(BETA)) u_round (
      .mode(mode), .x(xs[i]), .y(ys[i]), .k(ks[i]), .xo(xs[i+1]), .yo(ys[i+1])
    );
  end
  assign in_ready = state == S_IDLE;
  assign last = mode ? idx == IW'(UNROLL - 1) : idx == IW'(ROUNDS - UNROLL);
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      idx <= '0;
      x <= '0;
      y <= '0;
      mode <= MODE_ENC;
      out_valid <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      out_mode <= 1'b0;
    end
`ifdef SPECK_ABORT_EN
    else if (abort) begin
      if (state != S_IDLE) begin
        state <= S_IDLE;
        idx <= '0;
        x <= '0;
        y <= '0;
        out_valid <= 1'b0;
        out_x <= '0;
        out_y <= '0;
      end
    end
`endif
    else
      case (state)
        S_IDLE:
          if (in_valid) begin
            x <= in_x;
            y <= in_y;
            mode <= in_mode;
            idx <= in_mode == MODE_DEC ? IW'(ROUNDS - 1) : '0;
            state <= S_RUN;
          end
        S_RUN: begin
          x <= xs[UNROLL];
          y <= ys[UNROLL];
          if (last) begin
            out_x <= xs[UNROLL];
            out_y <= ys[UNROLL];
            out_mode <= mode;
            out_valid <= 1'b1;
            idx <= '0;
            state <= S_DONE;
          end else
            idx <= mode ? idx - IW'(UNROLL) : idx + IW'(UNROLL);
        end
        S_DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_speck_cipher_engine.sv
// tb_speck_cipher_engine: vector, random-vs-model, backpressure, reset and abort checks for the Speck engine
module tb_speck_cipher_engine;
  localparam int W = 32, R = 27;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, in_mode = 0, out_ready = 0;
  logic in_ready, out_valid, out_mode;
  logic [W-1:0] in_x = 0, in_y = 0, out_x, out_y;
  logic [W*R-1:0] rk_flat = 0, rk3_flat = 0;
  logic v3 = 0, m3 = 0, or3 = 0, r3, ov3, om3;
  logic [31:0] x3 = 0, y3 = 0, ox3, oy3;
  logic v16 = 0, m16 = 0, or16 = 0, r16, ov16, om16;
  logic [15:0] x16 = 0, y16 = 0, ox16, oy16;
  logic [16*22-1:0] rk16_flat = 0;
`ifdef SPECK_ABORT_EN
  logic abort = 0;
`endif
  int checks = 0, errors = 0;
  logic [63:0] ks [34];

  speck_cipher_engine #(.W(32), .ROUNDS(27), .UNROLL(1)) dut (
    .clk(clk), .rst(rst),
`ifdef SPECK_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_x(in_x), .in_y(in_y),
    .rk_flat(rk_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_mode(out_mode));
  speck_cipher_engine #(.W(32), .ROUNDS(27), .UNROLL(3)) dut3 (
    .clk(clk), .rst(rst),
`ifdef SPECK_ABORT_EN
    .abort(abort),
`endif
    .in_valid(v3), .in_ready(r3), .in_mode(m3), .in_x(x3), .in_y(y3),
    .rk_flat(rk3_flat), .out_valid(ov3), .out_ready(or3),
    .out_x(ox3), .out_y(oy3), .out_mode(om3));
  speck_cipher_engine #(.W(16), .ROUNDS(22), .UNROLL(2)) dut16 (
    .clk(clk), .rst(rst),
`ifdef SPECK_ABORT_EN
    .abort(abort),
`endif
    .in_valid(v16), .in_ready(r16), .in_mode(m16), .in_x(x16), .in_y(y16),
    .rk_flat(rk16_flat), .out_valid(ov16), .out_ready(or16),
    .out_x(ox16), .out_y(oy16), .out_mode(om16));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int r, input int w);
    logic [63:0] m = (64'd1 << w) - 1;
    v = v & m;
    return ((v >> r) | (v << (w - r))) & m;
  endfunction
  function automatic logic [63:0] rotl(input logic [63:0] v, input int r, input int w);
    return rotr(v, w - r, w);
  endfunction

  // Behavioural Speck: whole-block encryption or decryption over n keys
  function automatic logic [127:0] model(input logic md, input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] k [34], input int n, input int w);
    logic [63:0] m = (64'd1 << w) - 1;
    int a = w == 16 ? 7 : 8;
    int b = w == 16 ? 2 : 3;
    if (!md)
      for (int i = 0; i < n; i++) begin
        x = ((rotr(x, a, w) + y) & m) ^ k[i];
        y = rotl(y, b, w) ^ x;
      end
    else
      for (int i = n - 1; i >= 0; i--) begin
        y = rotr(x ^ y, b, w);
        x = rotl((x ^ k[i]) - y, a, w);
      end
    return {x, y};
  endfunction

  task automatic expand(input logic [63:0] k0, input logic [63:0] l0, input logic [63:0] l1,
                        input logic [63:0] l2, input int n, input int w);
    logic [63:0] l [40];
    logic [63:0] m = (64'd1 << w) - 1;
    int a = w == 16 ? 7 : 8;
    int b = w == 16 ? 2 : 3;
    ks[0] = k0; l[0] = l0; l[1] = l1; l[2] = l2;
    for (int i = 0; i < n - 1; i++) begin
      l[i+3] = ((ks[i] + rotr(l[i], a, w)) & m) ^ 64'(i);
      ks[i+1] = rotl(ks[i], b, w) ^ l[i+3];
    end
  endtask

  task automatic send(input logic m, input logic [31:0] x, input logic [31:0] y);
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL send_timeout: in_ready stuck at 0"); end
    in_valid = 1; in_mode = m; in_x = x; in_y = y;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("post_handshake_out_valid", out_valid, 0);
    chk("post_handshake_in_ready", in_ready, 1);
  endtask

  task automatic run3(input logic m, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ex, input logic [31:0] ey);
    int lat = 0;
    chk("u3_in_ready", r3, 1);
    v3 = 1; m3 = m; x3 = x; y3 = y;
    @(posedge clk); #1;
    v3 = 0;
    while (!ov3 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("u3_latency", lat, 9);
    chk("u3_x", ox3, ex);
    chk("u3_y", oy3, ey);
    chk("u3_mode", om3, m);
    or3 = 1; @(posedge clk); #1; or3 = 0;
  endtask

  task automatic run16(input logic m, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ex, input logic [15:0] ey);
    int lat = 0;
    chk("w16_in_ready", r16, 1);
    v16 = 1; m16 = m; x16 = x; y16 = y;
    @(posedge clk); #1;
    v16 = 0;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("w16_latency", lat, 11);
    chk("w16_x", ox16, ex);
    chk("w16_y", oy16, ey);
    chk("w16_mode", om16, m);
    or16 = 1; @(posedge clk); #1; or16 = 0;
  endtask

  typedef struct {
    logic mode;
    logic [31:0] x, y, ex, ey;
  } vec_t;

  initial begin
    vec_t vecs [2];
    int lat;
    logic [127:0] exp;
    logic [31:0] sx, sy;
    logic md, stable, seen;
    vecs[0] = '{1'b0, 32'h3b726574, 32'h7475432d, 32'h8c6fa548, 32'h454e028b};
    vecs[1] = '{1'b1, 32'h8c6fa548, 32'h454e028b, 32'h3b726574, 32'h7475432d};
    expand(64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918, 27, 32);
    for (int i = 0; i < 27; i++) rk_flat[i*32 +: 32] = ks[i][31:0];
    rk3_flat = rk_flat;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_mode", out_mode, 0);

    foreach (vecs[i]) begin
      send(vecs[i].mode, vecs[i].x, vecs[i].y);
      chk("vec_in_ready_busy", in_ready, 0);
      wait_out(lat);
      chk("vec_latency", lat, 27);
      chk("vec_out_x", out_x, vecs[i].ex);
      chk("vec_out_y", out_y, vecs[i].ey);
      chk("vec_out_mode", out_mode, vecs[i].mode);
      take();
    end

    run3(1'b0, 32'h3b726574, 32'h7475432d, 32'h8c6fa548, 32'h454e028b);
    run3(1'b1, 32'h8c6fa548, 32'h454e028b, 32'h3b726574, 32'h7475432d);

    expand(64'h0100, 64'h0908, 64'h1110, 64'h1918, 22, 16);
    for (int i = 0; i < 22; i++) rk16_flat[i*16 +: 16] = ks[i][15:0];
    run16(1'b0, 16'h6574, 16'h694c, 16'ha868, 16'h42f2);
    run16(1'b1, 16'ha868, 16'h42f2, 16'h6574, 16'h694c);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 27; i++) ks[i] = 64'($urandom);
      for (int i = 0; i < 27; i++) rk_flat[i*32 +: 32] = ks[i][31:0];
      md = 1'($urandom_range(1));
      sx = $urandom; sy = $urandom;
      exp = model(md, 64'(sx), 64'(sy), ks, 27, 32);
      send(md, sx, sy);
      wait_out(lat);
      chk("rand_latency", lat, 27);
      chk("rand_out_x", out_x, exp[95:64]);
      chk("rand_out_y", out_y, exp[31:0]);
      chk("rand_out_mode", out_mode, md);
      take();
    end

    sx = $urandom; sy = $urandom;
    exp = model(1'b0, 64'(sx), 64'(sy), ks, 27, 32);
    send(1'b0, sx, sy);
    wait_out(lat);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1; in_mode = 1; in_x = ~sx; in_y = ~sy;
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_x !== exp[95:64] || out_y !== exp[31:0]) stable = 0;
    end
    in_valid = 0;
    chk("bp_stable", stable, 1);
    take();
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || !in_ready) seen = 1; end
    chk("bp_extra_ignored", seen, 0);

    send(1'b0, sx, sy);
    repeat (10) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("midrst_no_stale", seen, 0);

`ifdef SPECK_ABORT_EN
    send(1'b0, sx, sy);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_run_in_ready", in_ready, 1);
    chk("abort_run_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("abort_run_no_result", seen, 0);
    abort = 1; in_valid = 1; in_x = sx; in_y = sy; in_mode = 0;
    @(posedge clk); #1 abort = 0; in_valid = 0;
    chk("abort_idle_not_taken", in_ready, 1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("abort_idle_no_result", seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
